// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch-side initiator for a zero-latency, byte-addressed
//                instruction memory. Holds the fetch PC and captures returned
//                instructions into a small prefetch queue. The queue head is
//                presented to decode with a valid/ready handshake. A redirect
//                flushes the queue and restarts fetch at the target.
//                Optional build macro FETCH_PERF_CNT_EN adds the
//                perf_fetch_cnt and perf_stall_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int                ADDR_W      = 16,
  parameter int                INSTR_W     = 16,
  parameter int                QUEUE_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] c_pc_step   = ADDR_W'(INSTR_W / 8);
  localparam logic [ADDR_W-1:0] c_align_msk = ~ADDR_W'(1);
  localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(QUEUE_DEPTH);

  // Queue occupancy states
  localparam logic [1:0] c_st_empty   = 2'd0;
  localparam logic [1:0] c_st_partial = 2'd1;
  localparam logic [1:0] c_st_full    = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic               w_pop;
  logic               w_push;
  logic [ADDR_W-1:0]  w_redirect_target;

  logic [ADDR_W-1:0]  r_q_pc    [QUEUE_DEPTH];
  logic [INSTR_W-1:0] r_q_instr [QUEUE_DEPTH];

  assign imem_addr = r_fetch_pc;
  assign if_instr  = r_q_instr[r_rd_ptr];
  assign if_pc     = r_q_pc[r_rd_ptr];

  // Handshake decode: pop on accepted head, push whenever there is room
  // (including the slot freed by a same-cycle pop) and no redirect.
  always_comb begin
    w_pop             = if_valid & id_ready;
    w_push            = ~redirect & ((r_count < c_depth) | w_pop);
    w_redirect_target = redirect_pc & c_align_msk;
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_empty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next occupancy: redirect flushes, otherwise count moves by push - pop
  always_comb begin
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = '0;
    end else if (w_push & ~w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop & ~w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end

    w_state_next = c_st_partial;
    if (w_count_next == '0) begin
      w_state_next = c_st_empty;
    end else if (w_count_next == c_depth) begin
      w_state_next = c_st_full;
    end
  end

  // Head is valid in any state except EMPTY
  always_comb begin
    if_valid = 1'b0;
    if (r_state != c_st_empty) begin
      if_valid = 1'b1;
    end
  end

  // Fetch PC, occupancy count and queue pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_fetch_pc <= w_redirect_target;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + c_pc_step;
          r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Queue storage: capture {fetch_pc, imem_instr} at the write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
      r_q_instr[r_wr_ptr] <= imem_instr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running performance counters; only reset clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_push) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (if_valid & ~id_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit. The
//                instruction memory returns A>>1 for byte address A.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Zero-latency memory model
  assign imem_instr = imem_addr >> 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"},    32'(if_pc),    32'(pc));
    chk({tag, "_instr"}, 32'(if_instr), 32'(pc >> 1));
  endtask

  initial begin
    rst         = 1'b1;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    step();
    step();

    // Reset state
    chk("rst_valid", 32'(if_valid),  32'd0);
    chk("rst_pc",    32'(if_pc),     32'd0);
    chk("rst_instr", 32'(if_instr),  32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);

    // Streaming with id_ready held high
    id_ready = 1'b1;
    rst      = 1'b0;
    step(); chk_head("stream0", 16'h0000);
    step(); chk_head("stream1", 16'h0002);
    step(); chk_head("stream2", 16'h0004);
    step(); chk_head("stream3", 16'h0006);

    // Backpressure after a fresh reset
    rst      = 1'b1;
    id_ready = 1'b0;
    #1;
    rst = 1'b0;
    step(); step(); step(); step(); step();
    chk("bp_addr_hold", 32'(imem_addr), 32'h0004);
    chk_head("bp_head", 16'h0000);
    id_ready = 1'b1;
    step(); chk_head("bp_resume1", 16'h0002);
    step(); chk_head("bp_resume2", 16'h0004);
    step(); chk_head("bp_resume3", 16'h0006);

    // Redirect with a full queue (odd target is aligned down)
    id_ready = 1'b0;
    step(); step();
    chk("full_addr", 32'(imem_addr), 32'h000A);
    redirect    = 1'b1;
    redirect_pc = 16'h0041;
    step();
    chk("redir_valid0", 32'(if_valid),  32'd0);
    chk("redir_addr",   32'(imem_addr), 32'h0040);
    redirect = 1'b0;
    step(); chk_head("redir_tgt", 16'h0040);

    // Simultaneous pop and redirect
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    step(); chk_head("pr_head", 16'h0010);
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    chk("pr_valid0", 32'(if_valid), 32'd0);
    redirect = 1'b0;
    step(); chk_head("pr_tgt0", 16'h0100);
    step(); chk_head("pr_tgt1", 16'h0102);

    // Back-to-back redirects: last one wins
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    step();
    chk("b2b_valid0", 32'(if_valid), 32'd0);
    redirect_pc = 16'h0300;
    step();
    chk("b2b_valid1", 32'(if_valid), 32'd0);
    redirect = 1'b0;
    step(); chk_head("b2b_tgt", 16'h0300);

    // Address wrap-around
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    step();
    redirect = 1'b0;
    step(); chk_head("wrap0", 16'hFFFC);
    step(); chk_head("wrap1", 16'hFFFE);
    step(); chk_head("wrap2", 16'h0000);
    step(); chk_head("wrap3", 16'h0002);

    // Async reset with two queued entries
    id_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(if_valid),  32'd0);
    chk("async_addr",  32'(imem_addr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("async_perf_stall", perf_stall_cnt, 32'd0);
`endif
    step();
    rst      = 1'b0;
    id_ready = 1'b1;
    step(); chk_head("restart", 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk("restart_perf_fetch", perf_fetch_cnt, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the byte-addressed, zero-latency 16-bit instruction memory.
- Holds the fetch PC, drives the memory address, and captures each returned instruction into a small prefetch queue.
- Presents instructions to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and restarting fetch at the target.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- INSTR_W, 16, instruction width; PC step is INSTR_W/8 = 2 bytes.
- QUEUE_DEPTH, 2, prefetch queue entries (power of two, 2..8).
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  byte address to instruction memory.
- imem_instr  in  INSTR_W  instruction returned combinationally for imem_addr.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  redirect target byte address.
- if_valid  out  1  queue head holds a valid instruction.
- if_instr  out  INSTR_W  queue head instruction.
- if_pc  out  ADDR_W  byte address of if_instr.
- id_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, queue count=0, rd/wr pointers=0, if_valid=0, if_instr=0, if_pc=0.
- imem_addr = fetch_pc, combinational from the register. Valid one cycle after reset deasserts.
- pop = if_valid & id_ready.
- push = !redirect & (count<QUEUE_DEPTH | pop).
- On push: write {fetch_pc, imem_instr} at wr_ptr. Then fetch_pc <= fetch_pc+2, wrapping modulo 2^ADDR_W, so 16'hFFFE goes to 16'h0000.
- Latency: an instruction is fetched in cycle N and appears on if_* in cycle N+1 when the queue was empty. There is no same-cycle bypass.
- Queue full and no pop: no push, and fetch_pc holds.
- Queue full and pop in the same cycle: push and pop together; count unchanged.
- Queue empty: if_valid=0. if_instr/if_pc hold their last values; they are don't-care for checking.
- Redirect (priority over everything):
  - count<=0 and pointers<=0.
  - fetch_pc <= redirect_pc with bit 0 forced to 0.
  - No push that cycle; the memory data for the old fetch_pc is discarded.
  - A pop in the same cycle is still a completed handshake: decode consumed the head. All other queued entries are dropped.
  - The first target instruction is valid on if_* two cycles after the redirect cycle.
- Back-to-back redirects: the last one wins; if_valid stays 0 until one cycle after the first non-redirect cycle.
- Steady state with id_ready=1 and no redirect: one instruction per cycle, and if_pc increments by 2 every cycle.
- Reset mid-operation: all state returns to reset values immediately (async); in-flight queue contents are lost.
- Count width is clog2(QUEUE_DEPTH)+1; pointers wrap at QUEUE_DEPTH.
- Internal state (conceptual FSM): EMPTY (count=0), PARTIAL, FULL (count=QUEUE_DEPTH). Transitions are driven solely by push/pop/redirect as defined above.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output perf_fetch_cnt [31:0] (increments on each push) and output perf_stall_cnt [31:0] (increments on each cycle with if_valid=1 and id_ready=0).
  - Both reset to 0 asynchronously and wrap silently.
  - Redirect does not clear them.
- Not defined: neither port nor any counter logic exists. Fetch behaviour is identical in both builds.

Test Plan:
- Bench memory model: instruction at byte address A equals A>>1.
- Reset release, id_ready=1 constant: cycle 1 after reset gives if_valid=1, if_pc=0x0000, if_instr=0x0000. Then if_pc 0x0002/0x0004/0x0006 with if_instr 0x0001/0x0002/0x0003, one per cycle.
- Backpressure: id_ready=0 for 5 cycles after reset.
  - Queue fills to 2 and fetch_pc holds at 0x0004; if_pc stays 0x0000.
  - On id_ready=1, the sequence continues 0x0000, 0x0002, 0x0004 with no gap and no duplicate.
- Redirect with full queue: redirect=1, redirect_pc=0x0041.
  - Queue is flushed and the next fetch address is 0x0040.
  - 2 cycles later: if_valid=1, if_pc=0x0040, if_instr=0x0020. No stale pre-redirect instruction appears.
- Simultaneous pop and redirect: head 0x0010 is accepted that cycle; the next valid if_pc is the target 0x0100.
  - Then if_pc 0x0102 follows.
- Wrap-around: redirect to 0xFFFC, id_ready=1 → if_pc sequence 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- Async reset asserted mid-stream with the queue holding 2 entries: if_valid drops to 0 without waiting for a clock edge. After release, fetch restarts at RESET_PC.
  - With FETCH_PERF_CNT_EN defined, both counters read 0.
